// File: rtl/clock_panel_ctrl_pkg.sv
// Shared encodings for the clock front-panel controller: display modes,
// edit-field codes, button indices and the edit FSM state type.
package clock_panel_pkg;

    localparam logic [1:0] MODE_ALARM  = 2'b00;
    localparam logic [1:0] MODE_CLOCK  = 2'b01;
    localparam logic [1:0] MODE_SWATCH = 2'b10;
    localparam logic [1:0] MODE_TIMER  = 2'b11;

    localparam logic [1:0] FIELD_NONE   = 2'b00;
    localparam logic [1:0] FIELD_HOUR   = 2'b01;
    localparam logic [1:0] FIELD_MINUTE = 2'b10;
    localparam logic [1:0] FIELD_SECOND = 2'b11;

    localparam int BTN_MODE = 0;
    localparam int BTN_SET  = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;
    localparam int NUM_BTN  = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_EDIT_H = 2'b01,
        ST_EDIT_M = 2'b10,
        ST_EDIT_S = 2'b11
    } state_t;

    function automatic logic [1:0] field_of(state_t s);
        case (s)
            ST_EDIT_H: return FIELD_HOUR;
            ST_EDIT_M: return FIELD_MINUTE;
            ST_EDIT_S: return FIELD_SECOND;
            default:   return FIELD_NONE;
        endcase
    endfunction

    // One-hot strobe select ordered {hour, minute, second}
    function automatic logic [2:0] strobe_of(state_t s);
        case (s)
            ST_EDIT_H: return 3'b100;
            ST_EDIT_M: return 3'b010;
            ST_EDIT_S: return 3'b001;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic state_t next_field(state_t s);
        case (s)
            ST_EDIT_H: return ST_EDIT_M;
            ST_EDIT_M: return ST_EDIT_S;
            default:   return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_panel_ctrl_btn_conditioner.sv
// Raw push-button conditioner: two-flop synchronizer, stability debounce,
// debounced level and a one-cycle press pulse on the level's rising edge.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    // The counter measures how long the synchronized input has disagreed with
    // the debounced level; any agreement restarts the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/clock_panel_ctrl.sv
// Front-panel controller: mode selection, field-edit FSM, inc/dec strobes with
// auto-repeat, stopwatch pause, alarm enable and edit-field blink.
module clock_panel_ctrl
    import clock_panel_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4,
    parameter int BLINK_HALF   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic       in_hour,
    output logic       in_minute,
    output logic       in_second,
    output logic       de_hour,
    output logic       de_minute,
    output logic       de_second,
    output logic       pause,
    output logic       alarm,
    output logic [1:0] field_sel,
    output logic       blink
);
    localparam int RCW = $clog2(REPEAT_DELAY + 1);
    localparam int BCW = $clog2(BLINK_HALF + 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_down, btn_up, btn_set, btn_mode};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_raw[gi]),
                .level (level[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // Only up/down levels drive behaviour (auto-repeat); mode/set act on presses.
    logic unused_levels;
    assign unused_levels = &{1'b0, level[BTN_SET:BTN_MODE]};

    state_t         state_reg, state_next;
    logic [1:0]     mode_reg, mode_next;
    logic           pause_sw_reg, pause_sw_next;
    logic           alarm_reg, alarm_next;
    logic           rep_on_reg, rep_on_next;
    logic           rep_up_reg, rep_up_next;
    logic [RCW-1:0] rep_cnt_reg, rep_cnt_next;
    logic [BCW-1:0] blink_cnt_reg, blink_cnt_next;
    logic           blink_reg, blink_next;
    logic [2:0]     in_reg, in_next;
    logic [2:0]     de_reg, de_next;
    logic           pause_reg, pause_next;
    logic [1:0]     field_sel_reg;

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        pause_sw_next  = pause_sw_reg;
        alarm_next     = alarm_reg;
        rep_on_next    = 1'b0;
        rep_up_next    = rep_up_reg;
        rep_cnt_next   = rep_cnt_reg;
        in_next        = 3'b000;
        de_next        = 3'b000;
        blink_next     = 1'b0;
        blink_cnt_next = '0;

        if (state_reg == ST_RUN) begin
            if (press[BTN_MODE]) begin
                mode_next = mode_reg + 2'd1;
                if (mode_reg == MODE_SWATCH) pause_sw_next = 1'b0;
            end else if (press[BTN_SET]) begin
                if (mode_reg == MODE_SWATCH) pause_sw_next = ~pause_sw_reg;
                else                         state_next    = ST_EDIT_H;
            end else if (press[BTN_UP] && mode_reg == MODE_CLOCK) begin
                alarm_next = ~alarm_reg;
            end
        end else begin
            if (press[BTN_MODE]) begin
                state_next = ST_RUN;
            end else if (press[BTN_SET]) begin
                state_next = next_field(state_reg);
            end else if (level[BTN_UP] && level[BTN_DOWN]) begin
                rep_on_next = 1'b0;
            end else if (press[BTN_UP] || press[BTN_DOWN]) begin
                rep_on_next  = 1'b1;
                rep_up_next  = press[BTN_UP];
                rep_cnt_next = RCW'(1);
                if (press[BTN_UP]) in_next = strobe_of(state_reg);
                else               de_next = strobe_of(state_reg);
            end else if (rep_on_reg && (rep_up_reg ? level[BTN_UP] : level[BTN_DOWN])) begin
                rep_on_next = 1'b1;
                // After the first repeat, rewind so the next one lands REPEAT_RATE later
                if (rep_cnt_reg == RCW'(REPEAT_DELAY - 1)) begin
                    rep_cnt_next = RCW'(REPEAT_DELAY - REPEAT_RATE);
                    if (rep_up_reg) in_next = strobe_of(state_reg);
                    else            de_next = strobe_of(state_reg);
                end else begin
                    rep_cnt_next = rep_cnt_reg + RCW'(1);
                end
            end
        end

        // Blink phase runs continuously across fields; entering from RUN restarts it.
        if (state_reg != ST_RUN && state_next != ST_RUN) begin
            if (blink_cnt_reg == BCW'(BLINK_HALF - 1)) begin
                blink_cnt_next = '0;
                blink_next     = ~blink_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BCW'(1);
                blink_next     = blink_reg;
            end
        end

        pause_next = pause_sw_next | (state_next != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            mode_reg      <= MODE_CLOCK;
            pause_sw_reg  <= 1'b0;
            alarm_reg     <= 1'b0;
            rep_on_reg    <= 1'b0;
            rep_up_reg    <= 1'b0;
            rep_cnt_reg   <= '0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            in_reg        <= 3'b000;
            de_reg        <= 3'b000;
            pause_reg     <= 1'b0;
            field_sel_reg <= FIELD_NONE;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            pause_sw_reg  <= pause_sw_next;
            alarm_reg     <= alarm_next;
            rep_on_reg    <= rep_on_next;
            rep_up_reg    <= rep_up_next;
            rep_cnt_reg   <= rep_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_reg     <= blink_next;
            in_reg        <= in_next;
            de_reg        <= de_next;
            pause_reg     <= pause_next;
            field_sel_reg <= field_of(state_next);
        end
    end

    assign mode      = mode_reg;
    assign in_hour   = in_reg[2];
    assign in_minute = in_reg[1];
    assign in_second = in_reg[0];
    assign de_hour   = de_reg[2];
    assign de_minute = de_reg[1];
    assign de_second = de_reg[0];
    assign pause     = pause_reg;
    assign alarm     = alarm_reg;
    assign field_sel = field_sel_reg;
    assign blink     = blink_reg;

endmodule

// File: tb/tb_clock_panel_ctrl.sv
// Self-checking bench for clock_panel_ctrl: directed scenarios plus random
// button activity, all compared cycle by cycle against a behavioural model.
module tb_clock_panel_ctrl;
    localparam int DC = 4;
    localparam int RD = 8;
    localparam int RR = 4;
    localparam int BH = 16;
    localparam logic [12:0] RESET_VEC = 13'b01_00_0_0_0_000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btns = 4'b0000;   // {down, up, set, mode}

    logic [1:0] mode, field_sel;
    logic       in_hour, in_minute, in_second, de_hour, de_minute, de_second;
    logic       pause, alarm, blink;

    clock_panel_ctrl #(
        .DEBOUNCE_CYC(DC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btns[0]),
        .btn_set   (btns[1]),
        .btn_up    (btns[2]),
        .btn_down  (btns[3]),
        .mode      (mode),
        .in_hour   (in_hour),
        .in_minute (in_minute),
        .in_second (in_second),
        .de_hour   (de_hour),
        .de_minute (de_minute),
        .de_second (de_second),
        .pause     (pause),
        .alarm     (alarm),
        .field_sel (field_sel),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    wire [12:0] dut_vec = {mode, field_sel, pause, alarm, blink,
                           in_hour, in_minute, in_second, de_hour, de_minute, de_second};

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mm_count = 0;
    logic [12:0] mm_obs, mm_exp;
    logic [12:0] exp_vec = RESET_VEC;
    int          cnt_in[3];
    int          cnt_de[3];
    int          in_hour_cyc[$];
    int          up_press_cyc = 0;

    // Behavioural model: raw history per button (hist[b][k] = raw value k cycles ago)
    bit hist[4][DC+3];
    bit m_lvl[4];
    int m_state = 0, m_mode = 1, m_edit_start = 0, m_t0 = 0;
    bit m_psw = 0, m_alarm = 0, m_rep_on = 0, m_rep_up = 0;

    task automatic model_advance();
        bit       lvl_now[4];
        bit       prs[4];
        bit       same;
        bit       bl;
        int       ns;
        int       d;
        logic [2:0] sin, sde, oh;
        // A debounced level takes a raw value once it has held for DC samples,
        // seen through the two-cycle synchronizer.
        for (int b = 0; b < 4; b++) begin
            same = 1'b1;
            for (int k = 4; k <= DC + 2; k++)
                if (hist[b][k] != hist[b][3]) same = 1'b0;
            lvl_now[b] = same ? hist[b][3] : m_lvl[b];
            prs[b] = lvl_now[b] && !m_lvl[b];
        end
        if (rst) begin
            m_state = 0; m_mode = 1; m_psw = 0; m_alarm = 0; m_rep_on = 0;
            for (int b = 0; b < 4; b++) begin
                m_lvl[b] = 1'b0;
                for (int k = 0; k <= DC + 2; k++) hist[b][k] = 1'b0;
            end
            exp_vec = RESET_VEC;
        end else begin
            if (prs[2]) up_press_cyc = cyc;
            sin = 3'b000;
            sde = 3'b000;
            ns = m_state;
            oh = (m_state == 0) ? 3'b000 : (3'b100 >> (m_state - 1));
            if (m_state == 0) begin
                m_rep_on = 0;
                if (prs[0]) begin
                    if (m_mode == 2) m_psw = 0;
                    m_mode = (m_mode + 1) % 4;
                end else if (prs[1]) begin
                    if (m_mode == 2) m_psw = !m_psw;
                    else ns = 1;
                end else if (prs[2] && m_mode == 1) begin
                    m_alarm = !m_alarm;
                end
            end else begin
                if (prs[0]) begin
                    ns = 0; m_rep_on = 0;
                end else if (prs[1]) begin
                    ns = (m_state + 1) % 4; m_rep_on = 0;
                end else if (lvl_now[2] && lvl_now[3]) begin
                    m_rep_on = 0;
                end else if (prs[2]) begin
                    sin = oh; m_rep_on = 1; m_rep_up = 1; m_t0 = cyc;
                end else if (prs[3]) begin
                    sde = oh; m_rep_on = 1; m_rep_up = 0; m_t0 = cyc;
                end else if (m_rep_on && (m_rep_up ? lvl_now[2] : lvl_now[3])) begin
                    d = cyc - m_t0;
                    if (d >= RD - 1 && (d - (RD - 1)) % RR == 0) begin
                        if (m_rep_up) sin = oh;
                        else          sde = oh;
                    end
                end else begin
                    m_rep_on = 0;
                end
            end
            if (ns != 0 && m_state == 0) m_edit_start = cyc + 1;
            m_state = ns;
            bl = (ns == 0) ? 1'b0 : ((((cyc + 1 - m_edit_start) / BH) % 2) == 1);
            exp_vec = {2'(m_mode), 2'(ns), (m_psw || ns != 0), m_alarm, bl, sin, sde};
            for (int b = 0; b < 4; b++) begin
                for (int k = DC + 2; k >= 2; k--) hist[b][k] = hist[b][k-1];
                hist[b][1] = btns[b];
                m_lvl[b] = lvl_now[b];
            end
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        if (dut_vec !== exp_vec) begin
            if (mm_count == 0) begin
                mm_obs = dut_vec;
                mm_exp = exp_vec;
            end
            mm_count++;
        end
        if (in_hour === 1'b1) begin cnt_in[0]++; in_hour_cyc.push_back(cyc); end
        if (in_minute === 1'b1) cnt_in[1]++;
        if (in_second === 1'b1) cnt_in[2]++;
        if (de_hour === 1'b1) cnt_de[0]++;
        if (de_minute === 1'b1) cnt_de[1]++;
        if (de_second === 1'b1) cnt_de[2]++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic tap(input int b);
        btns[b] = 1'b1;
        run(5);
        btns[b] = 1'b0;
        run(9);
        $display("tap btn=%0d cycle=%0d mode=%b field_sel=%b pause=%b alarm=%b",
                 b, cyc, mode, field_sel, pause, alarm);
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < 3; i++) begin cnt_in[i] = 0; cnt_de[i] = 0; end
        in_hour_cyc.delete();
        mm_count = 0;
    endtask

    function automatic int total_strobes();
        int s = 0;
        for (int i = 0; i < 3; i++) s += cnt_in[i] + cnt_de[i];
        return s;
    endfunction

    task automatic test_reset();
        clear_tallies();
        rst = 1'b1;
        btns = 4'b0000;
        run(3);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", dut_vec, RESET_VEC);
        end
        rst = 1'b0;
        run(4);
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected %b", dut_vec, RESET_VEC);
        end
        $display("reset done cycle=%0d", cyc);
    endtask

    task automatic test_mode_cycle();
        logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        clear_tallies();
        for (int i = 0; i < 4; i++) begin
            tap(0);
            checks++;
            if (mode !== seq[i] || pause !== 1'b0) begin
                errors++;
                $display("FAIL mode_step%0d: got mode=%b pause=%b expected mode=%b pause=0",
                         i, mode, pause, seq[i]);
            end
        end
        checks++;
        if (total_strobes() != 0) begin
            errors++;
            $display("FAIL mode_strobes: got %0d strobes expected 0", total_strobes());
        end
        checks++;
        if (mm_count != 0) begin
            errors++;
            $display("FAIL mode_model: %0d cycles differ, first got %b expected %b", mm_count, mm_obs, mm_exp);
        end
    endtask

    task automatic test_edit_sequence();
        logic [1:0] fs [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        int k = 0;
        clear_tallies();
        for (int i = 0; i < 6; i++) begin
            tap((i == 1) ? 2 : (i == 3) ? 3 : 1);
            if (i != 1 && i != 3) begin
                checks++;
                if (field_sel !== fs[k] || pause !== (fs[k] != 2'b00)) begin
                    errors++;
                    $display("FAIL edit_field%0d: got field_sel=%b pause=%b expected field_sel=%b pause=%b",
                             k, field_sel, pause, fs[k], fs[k] != 2'b00);
                end
                k++;
            end
        end
        checks++;
        if (cnt_in[0] != 1 || cnt_de[1] != 1 || total_strobes() != 2) begin
            errors++;
            $display("FAIL edit_strobes: got in_hour=%0d de_minute=%0d total=%0d expected 1 1 2",
                     cnt_in[0], cnt_de[1], total_strobes());
        end
        checks++;
        if (mm_count != 0) begin
            errors++;
            $display("FAIL edit_model: %0d cycles differ, first got %b expected %b", mm_count, mm_obs, mm_exp);
        end
    endtask

    task automatic test_repeat();
        int offs [7] = '{1, 8, 12, 16, 20, 24, 28};
        tap(1);
        clear_tallies();
        btns[2] = 1'b1;
        run(30);
        btns[2] = 1'b0;
        run(12);
        checks++;
        if (in_hour_cyc.size() != 7) begin
            errors++;
            $display("FAIL repeat_count: got %0d in_hour strobes expected 7", in_hour_cyc.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (in_hour_cyc[i] - up_press_cyc != offs[i]) begin
                    errors++;
                    $display("FAIL repeat_offset%0d: got press+%0d expected press+%0d",
                             i, in_hour_cyc[i] - up_press_cyc, offs[i]);
                end
            end
        end
        $display("repeat burst strobes=%0d press_cycle=%0d", in_hour_cyc.size(), up_press_cyc);
        tap(1); tap(1); tap(1);
        checks++;
        if (mm_count != 0 || field_sel !== 2'b00) begin
            errors++;
            $display("FAIL repeat_model: %0d cycles differ field_sel=%b, first got %b expected %b",
                     mm_count, field_sel, mm_obs, mm_exp);
        end
    endtask

    task automatic test_glitch_and_both();
        tap(1);
        clear_tallies();
        btns[2] = 1'b1;
        run(3);
        btns[2] = 1'b0;
        run(10);
        checks++;
        if (total_strobes() != 0) begin
            errors++;
            $display("FAIL glitch: got %0d strobes expected 0", total_strobes());
        end
        tap(1);
        btns[3:2] = 2'b11;
        run(20);
        btns[3:2] = 2'b00;
        run(10);
        checks++;
        if (total_strobes() != 0 || field_sel !== 2'b10) begin
            errors++;
            $display("FAIL both_held: got %0d strobes field_sel=%b expected 0 strobes field_sel=10",
                     total_strobes(), field_sel);
        end
        tap(1); tap(1);
        checks++;
        if (mm_count != 0) begin
            errors++;
            $display("FAIL glitch_model: %0d cycles differ, first got %b expected %b", mm_count, mm_obs, mm_exp);
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_p [3] = '{3'b1, 3'b0, 3'b1};
        clear_tallies();
        tap(0);
        for (int i = 0; i < 3; i++) begin
            tap(1);
            checks++;
            if (pause !== exp_p[i][0] || field_sel !== 2'b00) begin
                errors++;
                $display("FAIL pause_toggle%0d: got pause=%b field_sel=%b expected pause=%b field_sel=00",
                         i, pause, field_sel, exp_p[i][0]);
            end
        end
        tap(0);
        checks++;
        if (mode !== 2'b11 || pause !== 1'b0) begin
            errors++;
            $display("FAIL pause_leave: got mode=%b pause=%b expected mode=11 pause=0", mode, pause);
        end
        tap(0); tap(0);
        checks++;
        if (mode !== 2'b01 || mm_count != 0) begin
            errors++;
            $display("FAIL pause_model: mode=%b %0d cycles differ, first got %b expected %b",
                     mode, mm_count, mm_obs, mm_exp);
        end
    endtask

    task automatic test_reset_mid_edit();
        clear_tallies();
        tap(1); tap(1); tap(1);
        btns[2] = 1'b1;
        run(DC + 2 + 14);
        rst = 1'b1;
        btns[2] = 1'b0;
        step();
        checks++;
        if (dut_vec !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_edit: got %b expected %b", dut_vec, RESET_VEC);
        end
        rst = 1'b0;
        step();
        checks++;
        if (dut_vec[5:0] !== 6'b0 || mode !== 2'b01 || field_sel !== 2'b00) begin
            errors++;
            $display("FAIL reset_after: got %b expected %b", dut_vec, RESET_VEC);
        end
        run(10);
        tap(2);
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_toggle: got alarm=%b expected 1", alarm);
        end
        checks++;
        if (mm_count != 0) begin
            errors++;
            $display("FAIL reset_model: %0d cycles differ, first got %b expected %b", mm_count, mm_obs, mm_exp);
        end
    endtask

    task automatic test_random();
        int r;
        int len;
        clear_tallies();
        for (int i = 0; i < 70; i++) begin
            r = $urandom_range(0, 11);
            len = $urandom_range(1, 14);
            if (r == 11) begin
                rst = 1'b1;
                btns = 4'($urandom_range(0, 15));
                run(1);
                rst = 1'b0;
            end else begin
                btns = (r < 4) ? (4'b0001 << r) : (r == 4) ? 4'b1100 : 4'b0000;
                run(len);
            end
            $display("random step=%0d btns=%b len=%0d cycle=%0d mode=%b field_sel=%b",
                     i, btns, len, cyc, mode, field_sel);
        end
        btns = 4'b0000;
        run(20);
        checks++;
        if (mm_count != 0) begin
            errors++;
            $display("FAIL random_model: %0d cycles differ, first got %b expected %b", mm_count, mm_obs, mm_exp);
        end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_edit_sequence();
        test_repeat();
        test_glitch_and_both();
        test_pause();
        test_reset_mid_edit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
